// File: rtl/sel_encoder.sv
// Lowest-set-bit request encoder with a one-entry registered output stage,
// qualifier-rule checking (priority/unique/unique0) and saturating violation counters.
module sel_encoder #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ),
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_REQ-1:0] req,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic [SEL_W-1:0] sel,
    output logic             sel_none,
    output logic             err_multi,
    output logic             err_none,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] multi_cnt,
    output logic [CNT_W-1:0] none_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic             accept;
    logic             pop;
    logic             is_multi;
    logic             is_none;
    logic             hit_multi;
    logic             hit_none;
    logic             found;
    logic [SEL_W-1:0] enc;
    logic [N_REQ-1:0] req_m1;

    assign sel_valid = (state == FULL);
    assign req_ready = (state == EMPTY) || sel_ready;
    assign accept    = req_valid && req_ready;
    assign pop       = sel_valid && sel_ready;

    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign req_m1    = req - N_REQ'(1);
    assign is_none   = (req == '0);
    assign is_multi  = ((req & req_m1) != '0);
    assign hit_multi = is_multi && (MODE != 0);
    assign hit_none  = is_none && (MODE != 2);

    always_comb begin
        enc   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i] && !found) begin
                enc   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            sel       <= '0;
            sel_none  <= 1'b0;
            err_multi <= 1'b0;
            err_none  <= 1'b0;
            multi_cnt <= '0;
            none_cnt  <= '0;
        end else begin
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (pop && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (accept) begin
                sel      <= enc;
                sel_none <= is_none;
            end

            err_multi <= accept && hit_multi;
            err_none  <= accept && hit_none;

            if (clr_cnt)
                multi_cnt <= '0;
            else if (accept && hit_multi && (multi_cnt != '1))
                multi_cnt <= multi_cnt + CNT_W'(1);

            if (clr_cnt)
                none_cnt <= '0;
            else if (accept && hit_none && (none_cnt != '1))
                none_cnt <= none_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sel_encoder.sv
// Bench for sel_encoder: four instances (PRIORITY, UNIQUE, UNIQUE0, UNIQUE with 2-bit
// counters) driven in lockstep and compared against a transaction-level model.
module tb_sel_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req;
    logic       sel_ready;
    logic       clr_cnt;

    logic       rr [4];
    logic       sv [4];
    logic [1:0] so [4];
    logic       sn [4];
    logic       em [4];
    logic       en [4];
    logic [7:0] mc [4];
    logic [7:0] nc [4];
    logic [1:0] mc3, nc3;

    assign mc[3] = {6'b0, mc3};
    assign nc[3] = {6'b0, nc3};

    always #5 clk = ~clk;

    sel_encoder #(.N_REQ(4), .MODE(0), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[0]), .req(req),
        .sel_valid(sv[0]), .sel_ready(sel_ready), .sel(so[0]), .sel_none(sn[0]),
        .err_multi(em[0]), .err_none(en[0]), .clr_cnt(clr_cnt),
        .multi_cnt(mc[0]), .none_cnt(nc[0]));
    sel_encoder #(.N_REQ(4), .MODE(1), .CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[1]), .req(req),
        .sel_valid(sv[1]), .sel_ready(sel_ready), .sel(so[1]), .sel_none(sn[1]),
        .err_multi(em[1]), .err_none(en[1]), .clr_cnt(clr_cnt),
        .multi_cnt(mc[1]), .none_cnt(nc[1]));
    sel_encoder #(.N_REQ(4), .MODE(2), .CNT_W(8)) d2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[2]), .req(req),
        .sel_valid(sv[2]), .sel_ready(sel_ready), .sel(so[2]), .sel_none(sn[2]),
        .err_multi(em[2]), .err_none(en[2]), .clr_cnt(clr_cnt),
        .multi_cnt(mc[2]), .none_cnt(nc[2]));
    sel_encoder #(.N_REQ(4), .MODE(1), .CNT_W(2)) d3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[3]), .req(req),
        .sel_valid(sv[3]), .sel_ready(sel_ready), .sel(so[3]), .sel_none(sn[3]),
        .err_multi(em[3]), .err_none(en[3]), .clr_cnt(clr_cnt),
        .multi_cnt(mc3), .none_cnt(nc3));

    int total = 0;
    int bad   = 0;

    int modes [4] = '{0, 1, 2, 1};
    int cmax  [4] = '{255, 255, 255, 3};

    // Model: one pending result shared by all instances, per-instance pulses and counts.
    bit m_valid;
    int m_sel;
    bit m_none;
    bit m_em [4];
    bit m_en [4];
    int m_mc [4];
    int m_nc [4];

    typedef struct {
        logic [3:0] req;
        int         sel;
        bit         none;
        bit         multi;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic int low_index(input logic [3:0] v);
        logic [3:0] low;
        low = v & (~v + 4'd1);
        return $clog2(low);
    endfunction

    task automatic check_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s d%0d sel_valid", tag, d), int'(sv[d]), int'(m_valid));
            chk($sformatf("%s d%0d sel", tag, d), int'(so[d]), m_sel);
            chk($sformatf("%s d%0d sel_none", tag, d), int'(sn[d]), int'(m_none));
            chk($sformatf("%s d%0d err_multi", tag, d), int'(em[d]), int'(m_em[d]));
            chk($sformatf("%s d%0d err_none", tag, d), int'(en[d]), int'(m_en[d]));
            chk($sformatf("%s d%0d multi_cnt", tag, d), int'(mc[d]), m_mc[d]);
            chk($sformatf("%s d%0d none_cnt", tag, d), int'(nc[d]), m_nc[d]);
        end
    endtask

    // One clock: check req_ready before the edge, advance the model, check outputs after.
    task automatic step(input string tag);
        bit acc, multi, none;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s d%0d req_ready", tag, d), int'(rr[d]), int'(!m_valid || sel_ready));
        acc   = req_valid && (!m_valid || sel_ready);
        multi = $countones(req) > 1;
        none  = (req == 4'd0);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_sel   = low_index(req);
            m_none  = none;
        end else if (m_valid && sel_ready) begin
            m_valid = 1'b0;
        end
        for (int d = 0; d < 4; d++) begin
            m_em[d] = acc && multi && (modes[d] != 0);
            m_en[d] = acc && none && (modes[d] != 2);
            if (clr_cnt) begin
                m_mc[d] = 0;
                m_nc[d] = 0;
            end else begin
                if (m_em[d] && m_mc[d] < cmax[d]) m_mc[d]++;
                if (m_en[d] && m_nc[d] < cmax[d]) m_nc[d]++;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        req_valid = 1'b0;
        sel_ready = 1'b0;
        clr_cnt   = 1'b0;
        req       = 4'd0;
        rst_n     = 1'b0;
        #1;
        m_valid = 1'b0;
        m_sel   = 0;
        m_none  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            m_em[d] = 1'b0;
            m_en[d] = 1'b0;
            m_mc[d] = 0;
            m_nc[d] = 0;
        end
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s d%0d req_ready after release", tag, d), int'(rr[d]), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic sr, input logic clr);
        req_valid = v;
        req       = r;
        sel_ready = sr;
        clr_cnt   = clr;
    endtask

    vec_t tbl [10];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        do_reset("reset");

        tbl[0] = '{4'b0010, 1, 1'b0, 1'b0};
        tbl[1] = '{4'b0000, 0, 1'b1, 1'b0};
        tbl[2] = '{4'b0110, 1, 1'b0, 1'b1};
        tbl[3] = '{4'b0001, 0, 1'b0, 1'b0};
        tbl[4] = '{4'b0010, 1, 1'b0, 1'b0};
        tbl[5] = '{4'b0100, 2, 1'b0, 1'b0};
        tbl[6] = '{4'b1000, 3, 1'b0, 1'b0};
        tbl[7] = '{4'b1111, 0, 1'b0, 1'b1};
        tbl[8] = '{4'b1010, 1, 1'b0, 1'b1};
        tbl[9] = '{4'b1100, 2, 1'b0, 1'b1};

        // Back-to-back accepts with sel_ready held high: one result per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].req, 1'b1, 1'b0);
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d sel_valid", i), int'(sv[1]), 1);
            chk($sformatf("tbl%0d sel", i), int'(so[1]), tbl[i].sel);
            chk($sformatf("tbl%0d sel_none", i), int'(sn[1]), int'(tbl[i].none));
            chk($sformatf("tbl%0d unique err_multi", i), int'(em[1]), int'(tbl[i].multi));
            chk($sformatf("tbl%0d unique err_none", i), int'(en[1]), int'(tbl[i].none));
            chk($sformatf("tbl%0d priority err_multi", i), int'(em[0]), 0);
            chk($sformatf("tbl%0d unique0 err_none", i), int'(en[2]), 0);
        end
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        step("drain");
        chk("drain sel_valid", int'(sv[1]), 0);
        chk("tbl unique multi_cnt", int'(mc[1]), 4);
        chk("tbl unique none_cnt", int'(nc[1]), 1);
        chk("tbl unique0 none_cnt", int'(nc[2]), 0);
        chk("tbl priority multi_cnt", int'(mc[0]), 0);

        // Backpressure: result held, second request refused until the pop.
        do_reset("reset_bp");
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        step("bp load");
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bp stall%0d", i));
            chk($sformatf("bp stall%0d sel", i), int'(so[1]), 3);
            chk($sformatf("bp stall%0d req_ready", i), int'(rr[1]), 0);
            chk($sformatf("bp stall%0d err_multi", i), int'(em[1]), 0);
        end
        drive(1'b1, 4'b0001, 1'b1, 1'b0);
        step("bp pop");
        chk("bp pop sel", int'(so[1]), 0);
        chk("bp pop sel_valid", int'(sv[1]), 1);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        step("bp drain");

        // Stalled error pulse lasts one cycle only.
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        step("pulse t1");
        chk("pulse t1 err_none", int'(en[1]), 1);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        step("pulse t2");
        chk("pulse t2 err_none", int'(en[1]), 0);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        step("pulse drain");

        // Saturation, clear priority, reset while FULL.
        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b1, 1'b0);
            step($sformatf("sat%0d", i));
        end
        chk("sat cnt2 none_cnt", int'(nc[3]), 3);
        chk("sat cnt8 none_cnt", int'(nc[1]), 5);
        chk("sat unique0 none_cnt", int'(nc[2]), 0);
        drive(1'b1, 4'b0000, 1'b1, 1'b1);
        step("sat clr");
        chk("sat clr cnt2 none_cnt", int'(nc[3]), 0);
        chk("sat clr cnt8 none_cnt", int'(nc[1]), 0);
        drive(1'b1, 4'b0110, 1'b0, 1'b0);
        step("midrst load");
        chk("midrst load sel_valid", int'(sv[1]), 1);
        do_reset("midrst");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
            step($sformatf("rnd%0d", i));
        end
        do_reset("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
